// File: rtl/swc_display_pkg.sv
// swc_display_pkg
// Shared constants for the stopwatch seven-segment display slice.
//   DIGITS   : number of multiplexed digits on the board (6)
//   DP_MASK  : digits whose decimal point is lit, giving XX.XX.XX
//   HEX_SEG  : nibble -> active-low {g,f,e,d,c,b,a} segment pattern
package swc_display_pkg;

  localparam int DIGITS = 6;

  localparam logic [5:0] DP_MASK = 6'b010100;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/swc_display_hex_seg.sv
// SwcDisplayHexSeg
// Combinational hex digit decoder for a common-anode display.
// Ports:
//   nibble : 4-bit value to show
//   segs   : active-low segments {g,f,e,d,c,b,a}
module SwcDisplayHexSeg
  import swc_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = HEX_SEG[nibble];

endmodule

// File: rtl/swc_display.sv
// swc_display
// Drives a six-digit, time-multiplexed, common-anode seven-segment display
// in hexadecimal from the stopwatch counter. The counter is snapshotted
// once per full scan (at the digit 5 -> 0 wrap) so a digit never tears.
// Parameters:
//   DigitCycles : clock cycles each digit stays lit (1 .. 65536)
// Ports:
//   clock   : single clock, shared with the counter source
//   reset   : synchronous, active-high
//   counter : 24-bit value to display, nibble 0 on the rightmost digit
//   ready   : snapshot is only taken while high at the scan boundary
//   seg     : active-low segments {dp,g,f,e,d,c,b,a}, registered
//   an      : active-low one-hot digit enable, an[0] rightmost, registered
//   stale   : set when the last scan boundary skipped its snapshot
// Configuration:
//   SWC_DISPLAY_LZB_EN : when defined, digits above the highest nonzero
//                        nibble are blanked (digit 0 is never blanked)
module swc_display
  import swc_display_pkg::*;
#(
  parameter int unsigned DigitCycles = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] counter,
  input  logic        ready,
  output logic [7:0]  seg,
  output logic [5:0]  an,
  output logic        stale
);

  localparam int DIV_W = (DigitCycles > 1) ? $clog2(DigitCycles) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DigitCycles - 1);
  localparam logic [2:0] DIG_LAST = 3'(DIGITS - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       dig;
  logic [23:0]      snap;
  logic [3:0]       nibble;
  logic             dp_on;
  logic [6:0]       digit_seg;
  logic             blank;

  // Nibble and decimal-point selection for the digit currently being scanned.
  always_comb begin
    nibble = 4'h0;
    dp_on  = 1'b0;
    case (dig)
      3'd0: begin nibble = snap[3:0];   dp_on = DP_MASK[0]; end
      3'd1: begin nibble = snap[7:4];   dp_on = DP_MASK[1]; end
      3'd2: begin nibble = snap[11:8];  dp_on = DP_MASK[2]; end
      3'd3: begin nibble = snap[15:12]; dp_on = DP_MASK[3]; end
      3'd4: begin nibble = snap[19:16]; dp_on = DP_MASK[4]; end
      3'd5: begin nibble = snap[23:20]; dp_on = DP_MASK[5]; end
      default: begin nibble = 4'h0; dp_on = 1'b0; end
    endcase
  end

  SwcDisplayHexSeg u_hex_seg (
    .nibble (nibble),
    .segs   (digit_seg)
  );

`ifdef SWC_DISPLAY_LZB_EN
  // A digit is a leading zero when it and every nibble above it are zero.
  always_comb begin
    blank = (dig != 3'd0) && ((snap >> {dig, 2'b00}) == 24'd0);
  end
`else
  assign blank = 1'b0;
`endif

  // Outputs are registered from the pre-update scan state, so each digit is
  // lit for exactly DigitCycles cycles and a fresh snapshot reaches digit 0
  // on the edge after the boundary. an and seg move on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      div   <= '0;
      dig   <= 3'd0;
      snap  <= 24'd0;
      stale <= 1'b0;
      an    <= 6'b111111;
      seg   <= 8'hFF;
    end else begin
      an  <= ~(6'b000001 << dig);
      seg <= blank ? 8'hFF : {~dp_on, digit_seg};
      if (div == DIV_LAST) begin
        div <= '0;
        if (dig == DIG_LAST) begin
          dig <= 3'd0;
          if (ready) begin
            snap  <= counter;
            stale <= 1'b0;
          end else begin
            stale <= 1'b1;
          end
        end else begin
          dig <= dig + 3'd1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_swc_display.sv
// tb_swc_display
// Self-checking bench for swc_display. Two instances share one clock:
// dut4 with DigitCycles=4 and dut1 with DigitCycles=1. Expected an/seg
// pairs are queued per cycle from an independent digit/segment model and
// popped as each registered output is sampled on the falling edge.
// Honours SWC_DISPLAY_LZB_EN when the RTL is built with it.
module tb_swc_display;

  logic        clock = 1'b0;
  logic        reset4, ready4, stale4;
  logic [23:0] counter4;
  logic [7:0]  seg4;
  logic [5:0]  an4;
  logic        reset1, ready1, stale1;
  logic [23:0] counter1;
  logic [7:0]  seg1;
  logic [5:0]  an1;

  typedef struct packed {
    logic [5:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  swc_display #(.DigitCycles(4)) dut4 (
    .clock   (clock),
    .reset   (reset4),
    .counter (counter4),
    .ready   (ready4),
    .seg     (seg4),
    .an      (an4),
    .stale   (stale4)
  );

  swc_display #(.DigitCycles(1)) dut1 (
    .clock   (clock),
    .reset   (reset1),
    .counter (counter1),
    .ready   (ready1),
    .seg     (seg1),
    .an      (an1),
    .stale   (stale1)
  );

  // Reference hex table, active-low gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [23:0] s, input int d);
    logic [23:0] t;
    t = s >> (4 * d);
`ifdef SWC_DISPLAY_LZB_EN
    if (d != 0 && t == 24'd0) return 8'hFF;
`endif
    return {((d == 2) || (d == 4)) ? 1'b0 : 1'b1, hex7(t[3:0])};
  endfunction

  function automatic logic [5:0] exp_an(input int d);
    logic [5:0] a;
    a = 6'b111111;
    a[d] = 1'b0;
    return a;
  endfunction

  // Queue expectations for scan positions start..start+n-1 of a scan showing
  // snapshot s, then step n clock edges comparing each registered output.
  task automatic run_cycles(input bit sel, input logic [23:0] s, input int dc,
                            input int start, input int n, input string name);
    exp_t       e;
    logic [5:0] oa;
    logic [7:0] os;
    for (int k = start; k < start + n; k++) begin
      e.an  = exp_an((k / dc) % 6);
      e.seg = exp_seg(s, (k / dc) % 6);
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      e  = sb.pop_front();
      oa = sel ? an1 : an4;
      os = sel ? seg1 : seg4;
      total++;
      if (oa !== e.an || os !== e.seg) begin
        bad++;
        $display("[TB] FAIL %s pos %0d: got an=%h seg=%h, want an=%h seg=%h",
                 name, start + i, oa, os, e.an, e.seg);
      end
    end
  endtask

  task automatic check_stale(input logic want, input string name);
    total++;
    if (stale4 !== want) begin
      bad++;
      $display("[TB] FAIL %s: got stale=%b, want %b", name, stale4, want);
    end
  endtask

  task automatic check_dark(input string name);
    total++;
    if (an4 !== 6'h3F) begin
      bad++;
      $display("[TB] FAIL %s an: got %h, want 3f", name, an4);
    end
    total++;
    if (seg4 !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL %s seg: got %h, want ff", name, seg4);
    end
  endtask

  task automatic test_reset;
    reset4 = 1'b1; ready4 = 1'b0; counter4 = 24'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_dark("reset_hold");
    check_stale(1'b0, "reset_stale");
    reset4   = 1'b0;
    counter4 = 24'hF2F1F0;
    ready4   = 1'b1;
    run_cycles(1'b0, 24'h0, 4, 0, 24, "first_scan");
    check_stale(1'b0, "first_boundary_stale");
  endtask

  task automatic test_snapshot;
    counter4 = 24'h123456;
    ready4   = 1'b0;
    run_cycles(1'b0, 24'hF2F1F0, 4, 0, 12, "snap_f2f1f0_a");
    ready4 = 1'b1;
    run_cycles(1'b0, 24'hF2F1F0, 4, 12, 4, "snap_f2f1f0_b");
    ready4 = 1'b0;
    run_cycles(1'b0, 24'hF2F1F0, 4, 16, 8, "snap_f2f1f0_c");
    check_stale(1'b1, "skipped_boundary_stale");
  endtask

  task automatic test_stale_recover;
    ready4 = 1'b1;
    run_cycles(1'b0, 24'hF2F1F0, 4, 0, 24, "held_scan");
    check_stale(1'b0, "recovered_stale");
    counter4 = 24'hF2F1F0;
    run_cycles(1'b0, 24'h123456, 4, 0, 24, "scan_123456");
  endtask

  task automatic test_reset_mid;
    counter4 = 24'h777777;
    ready4   = 1'b1;
    run_cycles(1'b0, 24'hF2F1F0, 4, 0, 14, "pre_reset");
    reset4 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_dark("mid_reset");
    check_stale(1'b0, "mid_reset_stale");
    reset4   = 1'b0;
    counter4 = 24'hF2F1F0;
    run_cycles(1'b0, 24'h0, 4, 0, 24, "after_mid_reset");
  endtask

  task automatic test_blanking;
    counter4 = 24'h0000A5;
    run_cycles(1'b0, 24'hF2F1F0, 4, 0, 24, "lead_in");
    counter4 = 24'h000000;
    run_cycles(1'b0, 24'h0000A5, 4, 0, 24, "scan_a5");
    run_cycles(1'b0, 24'h000000, 4, 0, 24, "scan_zero");
  endtask

  task automatic test_dc1;
    reset1 = 1'b1; counter1 = 24'hFFFFFF; ready1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    total++;
    if (an1 !== 6'h3F || seg1 !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL dc1_reset: got an=%h seg=%h, want an=3f seg=ff", an1, seg1);
    end
    reset1 = 1'b0;
    run_cycles(1'b1, 24'h0, 1, 0, 6, "dc1_first");
    run_cycles(1'b1, 24'hFFFFFF, 1, 0, 12, "dc1_ffffff");
  endtask

  initial begin
    reset1 = 1'b1; ready1 = 1'b0; counter1 = 24'd0;
    test_reset;
    test_snapshot;
    test_stale_recover;
    test_reset_mid;
    test_blanking;
    test_dc1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
